exc_irq_sequencer: RTL

- Exception/interrupt sequencer for the LEGv8 core.
- Takes external interrupt requests, decoder-flagged invalid opcodes and ERET decodes.
- Drives the Exc/ERet/EStatus contract into the datapath and completes the ExcAck handshake.
- Acknowledges the external interrupt source via ExtIAck, and masks further requests while a handler runs.

---
 rtl/exc_irq_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/exc_irq_sequencer.sv
// Exception/interrupt sequencer for the LEGv8 core.
// Arbitrates invalid-opcode, ERET and external IRQ events, drives the
// Exc/ERet/EStatus contract into the datapath, completes the ExcAck
// handshake and acknowledges the external interrupt source.
//
// Build option: define EXC_IRQ_SYNC_EN to pass ExtIRQ through a 2-flop
// synchronizer (ExtIRQ -> Exc latency becomes 3 cycles). Without it,
// ExtIRQ must already be synchronous to clk (latency 1 cycle).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no exception in flight, arbitrating new events
// REQ     | Exc asserted, waiting for ExcAck from the datapath
// HANDLER | handler running, interrupts masked, EStatus readable
// RETURN  | one-cycle ERet strobe, EStatus cleared, mask released

module exc_irq_sequencer #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ExtIRQ,
    input  logic       NotAnInstr,
    input  logic       ERetInstr,
    input  logic       ExcAck,
    output logic       Exc,
    output logic       ERet,
    output logic [3:0] EStatus,
    output logic       ExtIAck,
    output logic       Masked,
    output logic       AckTimeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    localparam logic [3:0] CAUSE_NONE   = 4'b0000;
    localparam logic [3:0] CAUSE_IRQ    = 4'b0001;
    localparam logic [3:0] CAUSE_BADOP  = 4'b0010;
    localparam logic [3:0] CAUSE_ERET   = 4'b0011;
    localparam logic [3:0] CAUSE_DOUBLE = 4'b0100;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       estatus_q, estatus_d;
    logic             masked_q, masked_d;
    logic             irq_pend_q, irq_pend_d;
    logic             ext_iack_q, ext_iack_d;
    logic             ack_timeout_q, ack_timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ext_irq;
    logic             irq_req;

`ifdef EXC_IRQ_SYNC_EN
    logic [1:0] irq_sync_q;

    // Two-flop synchronizer for the asynchronous interrupt line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_sync_q <= 2'b00;
        end else begin
            irq_sync_q <= {irq_sync_q[0], ExtIRQ};
        end
    end

    assign ext_irq = irq_sync_q[1];
`else
    assign ext_irq = ExtIRQ;
`endif

    // A live, unmasked request is taken in the same cycle it is first seen,
    // so IDLE does not have to wait for irq_pend to register.
    assign irq_req = irq_pend_q | (ext_irq & ~masked_q);

    // State and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            estatus_q     <= CAUSE_NONE;
            masked_q      <= 1'b0;
            irq_pend_q    <= 1'b0;
            ext_iack_q    <= 1'b0;
            ack_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            estatus_q     <= estatus_d;
            masked_q      <= masked_d;
            irq_pend_q    <= irq_pend_d;
            ext_iack_q    <= ext_iack_d;
            ack_timeout_q <= ack_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state, cause latching, mask, pending IRQ and timeout logic.
    always_comb begin
        state_d       = state_q;
        estatus_d     = estatus_q;
        masked_d      = masked_q;
        irq_pend_d    = irq_pend_q;
        ext_iack_d    = 1'b0;
        ack_timeout_d = ack_timeout_q;
        cnt_d         = '0;

        case (state_q)
            ST_IDLE: begin
                if (NotAnInstr) begin
                    state_d   = ST_REQ;
                    estatus_d = CAUSE_BADOP;
                end else if (ERetInstr) begin
                    state_d   = ST_REQ;
                    estatus_d = CAUSE_ERET;
                end else if (irq_req) begin
                    state_d   = ST_REQ;
                    estatus_d = CAUSE_IRQ;
                end
            end
            ST_REQ: begin
                if (ExcAck) begin
                    state_d    = ST_HANDLER;
                    masked_d   = 1'b1;
                    ext_iack_d = (estatus_q == CAUSE_IRQ);
                end
            end
            ST_HANDLER: begin
                // A fault inside the handler beats its own ERET.
                if (NotAnInstr) begin
                    state_d   = ST_REQ;
                    estatus_d = CAUSE_DOUBLE;
                end else if (ERetInstr) begin
                    state_d   = ST_RETURN;
                    estatus_d = CAUSE_NONE;
                    masked_d  = 1'b0;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                estatus_d = CAUSE_NONE;
                masked_d  = 1'b0;
            end
        endcase

        // Counter holds the number of the current Exc cycle, saturating at
        // the timeout so a long stall cannot wrap it.
        if (state_d == ST_REQ) begin
            if (state_q == ST_REQ) begin
                cnt_d = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_ONE;
            end else begin
                cnt_d = CNT_ONE;
            end
        end

        if ((state_d == ST_REQ) && (cnt_d == TIMEOUT_C)) begin
            ack_timeout_d = 1'b1;
        end

        // The acknowledge retires the request; while masked a new one
        // cannot be recorded, so a level still high after ERET re-arms.
        if (ext_iack_q) begin
            irq_pend_d = 1'b0;
        end else if (ext_irq && !masked_q) begin
            irq_pend_d = 1'b1;
        end
    end

    assign Exc        = (state_q == ST_REQ);
    assign ERet       = (state_q == ST_RETURN);
    assign EStatus    = estatus_q;
    assign ExtIAck    = ext_iack_q;
    assign Masked     = masked_q;
    assign AckTimeout = ack_timeout_q;

`ifndef SYNTHESIS
    // Exc and ERet come from distinct states and must never overlap.
    a_exc_eret_excl: assert property (@(posedge clk) disable iff (reset)
        !(Exc && ERet));

    // The interrupt acknowledge is only issued once the handler has begun.
    a_iack_masked: assert property (@(posedge clk) disable iff (reset)
        ExtIAck |-> Masked);
`endif

endmodule
